byte_packer: RTL and testbench



---
 rtl/byte_packer.sv | 149 ++++++++++++++
 tb/tb_byte_packer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// byte_packer
//   Byte-to-wide deserializer. Collects an 8-bit byte stream (valid/ready)
//   into a NBYTES*8-bit frame, first byte in the top bits, and presents the
//   frame with its destination ip/port on a valid/ready output handshake.
//
//   Ports:
//     clk, rstn         clock (rising edge), asynchronous active-low reset
//     ip, port          destination tag, sampled on the edge that closes a frame
//     istart            marks ibyte as the first byte of a new packet
//     ivalid, ibyte     input byte stream
//     iready            byte accepted when ivalid && iready
//     flush             closes the current partial frame
//     ovalid, oready    frame handshake
//     data_out          packed frame, first byte at [W-1:W-8], zero padded
//     olen              number of valid bytes in data_out (1..NBYTES)
//     oip, oport        ip/port latched with the frame
//     ocsum             16-bit ones-complement sum of the frame bytes
//                       (only with BYTE_PACKER_CSUM_EN defined)
//
//   Optional feature macro: BYTE_PACKER_CSUM_EN
module byte_packer #(
   parameter int unsigned NBYTES = 69,
   parameter int unsigned CNTW   = 7
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [31:0]           ip,
   input  logic [15:0]           port,
   input  logic                  istart,
   input  logic                  ivalid,
   input  logic [7:0]            ibyte,
   output logic                  iready,
   input  logic                  flush,
   output logic                  ovalid,
   input  logic                  oready,
   output logic [NBYTES*8-1:0]   data_out,
   output logic [CNTW-1:0]       olen,
   output logic [31:0]           oip,
   output logic [15:0]           oport
`ifdef BYTE_PACKER_CSUM_EN
   ,
   output logic [15:0]           ocsum
`endif
);

   localparam int unsigned     W       = NBYTES * 8;
   localparam logic [CNTW-1:0] LP_FULL = CNTW'(NBYTES);

   typedef enum logic {ST_FILL, ST_HOLD} state_t;

   state_t          r_state;
   logic [CNTW-1:0] r_count;
   logic [W-1:0]    r_shift;

   logic            w_in_fill;
   logic            w_start_close;
   logic            w_accept;
   logic            w_close;
   logic [CNTW-1:0] w_next_count;
   logic [W-1:0]    w_next_shift;
   logic [31:0]     w_shamt;
   logic [W-1:0]    w_frame;

   always_comb begin
      w_in_fill     = (r_state == ST_FILL);
      // istart on a non-empty frame is held off and closes the frame instead
      w_start_close = w_in_fill && istart && ivalid && (r_count != '0);
      iready        = w_in_fill && !(istart && ivalid && (r_count != '0));
      w_accept      = ivalid && iready;
      w_next_shift  = w_accept ? {r_shift[W-9:0], ibyte} : r_shift;
      w_next_count  = w_accept ? (r_count + CNTW'(1)) : r_count;
      // a byte accepted together with flush is part of the closing frame
      w_close       = w_in_fill &&
                      ((w_accept && (w_next_count == LP_FULL)) ||
                       (flush && (w_next_count != '0)) ||
                       w_start_close);
      // left-align: shift up by the number of missing bytes
      w_shamt       = (NBYTES - 32'(w_next_count)) << 3;
      w_frame       = w_next_shift << w_shamt;
   end

`ifdef BYTE_PACKER_CSUM_EN
   logic [15:0] r_csum;
   logic [15:0] w_word;
   logic [16:0] w_sum17;
   logic [15:0] w_csum_add;
   logic [15:0] w_next_csum;

   always_comb begin
      // even-index byte is the high octet of its 16-bit word
      w_word      = r_count[0] ? {8'h00, ibyte} : {ibyte, 8'h00};
      w_sum17     = {1'b0, r_csum} + {1'b0, w_word};
      w_csum_add  = w_sum17[15:0] + {15'b0, w_sum17[16]};
      w_next_csum = w_accept ? w_csum_add : r_csum;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_csum <= '0;
         ocsum  <= '0;
      end else if (r_state == ST_FILL) begin
         r_csum <= w_next_csum;
         if (w_close) begin
            ocsum <= w_next_csum;
         end
      end else if (oready) begin
         r_csum <= '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_FILL;
         r_count  <= '0;
         r_shift  <= '0;
         data_out <= '0;
         olen     <= '0;
         oip      <= '0;
         oport    <= '0;
         ovalid   <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               r_shift <= w_next_shift;
               r_count <= w_next_count;
               if (w_close) begin
                  data_out <= w_frame;
                  olen     <= w_next_count;
                  oip      <= ip;
                  oport    <= port;
                  ovalid   <= 1'b1;
                  r_state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (oready) begin
                  ovalid  <= 1'b0;
                  r_count <= '0;
                  r_shift <= '0;
                  r_state <= ST_FILL;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

   localparam int unsigned NB = 69;
   localparam int unsigned CW = 7;
   localparam int unsigned W  = NB * 8;

   logic          clk;
   logic          rstn;
   logic [31:0]   ip;
   logic [15:0]   port;
   logic          istart;
   logic          ivalid;
   logic [7:0]    ibyte;
   logic          iready;
   logic          flush;
   logic          ovalid;
   logic          oready;
   logic [W-1:0]  data_out;
   logic [CW-1:0] olen;
   logic [31:0]   oip;
   logic [15:0]   oport;
`ifdef BYTE_PACKER_CSUM_EN
   logic [15:0]   ocsum;
`endif

   byte_packer #(.NBYTES(NB), .CNTW(CW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ip       (ip),
      .port     (port),
      .istart   (istart),
      .ivalid   (ivalid),
      .ibyte    (ibyte),
      .iready   (iready),
      .flush    (flush),
      .ovalid   (ovalid),
      .oready   (oready),
      .data_out (data_out),
      .olen     (olen),
      .oip      (oip),
      .oport    (oport)
`ifdef BYTE_PACKER_CSUM_EN
      ,
      .ocsum    (ocsum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  len;
      logic [31:0]  ip;
      logic [15:0]  port;
      logic [15:0]  csum;
   } frame_t;

   frame_t     sb[$];
   logic [7:0] mbytes[$];
   int         checks = 0;
   int         errors = 0;
   int         ready_mode = 1;   // 0: forced_ready, 1: always 1, 2: random
   logic       forced_ready = 1'b1;

   always @(posedge clk) begin
      #2;
      if (ready_mode == 0)      oready = forced_ready;
      else if (ready_mode == 1) oready = 1'b1;
      else                      oready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference frame built directly from the list of accepted bytes.
   function automatic frame_t build_frame();
      frame_t      f;
      int unsigned s;
      f.data = '0;
      s      = 0;
      for (int i = 0; i < mbytes.size(); i++) begin
         f.data[W-1-8*i -: 8] = mbytes[i];
         s += (i % 2 == 0) ? 32'({mbytes[i], 8'h00}) : 32'({8'h00, mbytes[i]});
      end
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      f.len  = mbytes.size();
      f.ip   = ip;
      f.port = port;
      f.csum = s[15:0];
      return f;
   endfunction

   task automatic close_frame();
      sb.push_back(build_frame());
      mbytes.delete();
   endtask

   // Scoreboard monitor: compares each frame at its handshake.
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (rstn && ovalid && oready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame actual=valid required=none");
            end else begin
               f = sb.pop_front();
               chk("frame_data", data_out, f.data);
               chk("frame_olen", W'(olen), W'(f.len));
               chk("frame_oip", W'(oip), W'(f.ip));
               chk("frame_oport", W'(oport), W'(f.port));
`ifdef BYTE_PACKER_CSUM_EN
               chk("frame_ocsum", W'(ocsum), W'(f.csum));
`endif
            end
         end
      end
   end

   task automatic wait_iready(output bit ok);
      int n = 0;
      while (!iready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = iready;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL iready_timeout actual=0 required=1");
      end
   endtask

   task automatic send(input logic [7:0] b, input bit st, input bit fl);
      bit ok;
      @(negedge clk);
      ibyte  = b;
      ivalid = 1'b1;
      istart = st;
      #1;
      if (st && mbytes.size() != 0) begin
         chk("istart_block", W'(iready), W'(1'b0));
         close_frame();
         @(posedge clk);
         #1;
         chk("istart_close_valid", W'(ovalid), W'(1'b1));
      end
      wait_iready(ok);
      if (ok) begin
         flush = fl;
         @(posedge clk);
         mbytes.push_back(b);
         if (fl || mbytes.size() == NB) begin
            close_frame();
            #1;
            chk("close_latency", W'(ovalid), W'(1'b1));
         end else begin
            #1;
         end
      end
      ivalid = 1'b0;
      istart = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic do_flush();
      bit ok;
      @(negedge clk);
      #1;
      wait_iready(ok);
      flush = 1'b1;
      @(posedge clk);
      if (mbytes.size() != 0) begin
         close_frame();
         #1;
         chk("flush_close_valid", W'(ovalid), W'(1'b1));
      end else begin
         #1;
         chk("flush_empty_ignored", W'(ovalid), W'(1'b0));
      end
      flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
   endtask

   initial begin
      rstn   = 1'b0;
      ip     = 32'hC0A80001;
      port   = 16'h1F90;
      istart = 1'b0;
      ivalid = 1'b0;
      ibyte  = 8'h00;
      flush  = 1'b0;
      oready = 1'b0;
      #1;
      chk("reset_ovalid", W'(ovalid), W'(1'b0));
      chk("reset_data", data_out, '0);
      chk("reset_olen", W'(olen), '0);
      chk("reset_oip", W'(oip), '0);
      chk("reset_oport", W'(oport), '0);
      chk("reset_iready", W'(iready), W'(1'b1));
`ifdef BYTE_PACKER_CSUM_EN
      chk("reset_ocsum", W'(ocsum), '0);
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // full frame 0x00..0x44
      for (int i = 0; i < 69; i++) send(8'(i), 1'b0, 1'b0);
      chk("full_first_byte", W'(data_out[W-1 -: 8]), W'(8'h00));
      chk("full_last_byte", W'(data_out[7:0]), W'(8'h44));
      chk("full_olen", W'(olen), W'(69));
      chk("full_oip", W'(oip), W'(32'hC0A80001));
      chk("full_oport", W'(oport), W'(16'h1F90));
      drain();

      // flush partial
      send(8'hAA, 1'b0, 1'b0);
      send(8'hBB, 1'b0, 1'b0);
      send(8'hCC, 1'b0, 1'b0);
      do_flush();
      chk("flush_top", W'(data_out[W-1 -: 24]), W'(24'hAABBCC));
      chk("flush_pad", W'(data_out[W-25:0]), '0);
      chk("flush_olen", W'(olen), W'(3));
      drain();
      do_flush();

      // istart split: 0x33 becomes a one-byte second frame
      ip   = 32'h0A000002;
      port = 16'h0050;
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h33, 1'b1, 1'b0);
      do_flush();
      drain();

      // backpressure
      ready_mode   = 0;
      forced_ready = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 69; i++) send(8'($urandom), 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_ovalid", W'(ovalid), W'(1'b1));
         chk("bp_iready", W'(iready), W'(1'b0));
         chk("bp_data", data_out, sb[0].data);
         chk("bp_olen", W'(olen), W'(sb[0].len));
      end
      forced_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_after_ovalid", W'(ovalid), W'(1'b0));
      chk("bp_after_iready", W'(iready), W'(1'b1));
      ready_mode = 1;
      drain();

      // reset mid-frame
      for (int i = 0; i < 30; i++) send(8'($urandom_range(1, 255)), 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst_mid_ovalid", W'(ovalid), W'(1'b0));
      chk("rst_mid_data", data_out, '0);
      chk("rst_mid_olen", W'(olen), '0);
      mbytes.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rst_release_iready", W'(iready), W'(1'b1));
      for (int i = 0; i < 69; i++) send(8'($urandom), 1'b0, 1'b0);
      drain();

`ifdef BYTE_PACKER_CSUM_EN
      send(8'h45, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h1C, 1'b0, 1'b0);
      do_flush();
      chk("csum_known", W'(ocsum), W'(16'h451C));
      drain();
`endif

      // randomized traffic with random sink readiness
      ready_mode = 2;
      for (int k = 0; k < 700; k++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 9) == 0) begin
            ip   = $urandom;
            port = 16'($urandom);
         end
         if (r < 4) do_flush();
         else send(8'($urandom), (r < 9), (r >= 9 && r < 12));
      end
      ready_mode = 1;
      do_flush();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
